// File: rtl/led_channel_animator.sv
// ---------------------------------------------------------------------------
// led_channel_animator
//
// Drives NUM_CH LED groups of LED_W bits each. The lowest-indexed requested
// channel animates one step every TICK_CYCLES clocks in one of four modes
// (rotate-left, rotate-right, blink, bounce); every other channel shows the
// IDLE pattern (bit 0 lit only).
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active-high
//   ch_sel        in   [NUM_CH]  channel request lines, lowest set index wins
//   mode          in   [2]       00 rotl, 01 rotr, 10 blink, 11 bounce
//   leds          out  [NUM_CH*LED_W] channel c at [c*LED_W +: LED_W], 1 = lit
//   active_valid  out  a channel is currently animating
//   active_idx    out  [IDX_W]   animating channel index, 0 when none
//   tick          out  one-cycle pulse after each animation step
// ---------------------------------------------------------------------------
module led_channel_animator #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int CNT_W       = 26,
    parameter int NUM_CH      = 7,
    parameter int LED_W       = 4,
    parameter int IDX_W       = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_sel,
    input  logic [1:0]              mode,
    output logic [NUM_CH*LED_W-1:0] leds,
    output logic                    active_valid,
    output logic [IDX_W-1:0]        active_idx,
    output logic                    tick
);

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'b00,
        MODE_ROTR   = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [LED_W-1:0] IDLE     = LED_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    // Elaboration-time parameter sanity checks.
    if (TICK_CYCLES < 2)                  $error("TICK_CYCLES must be >= 2");
    if ((2.0 ** CNT_W) < TICK_CYCLES)     $error("CNT_W too small for TICK_CYCLES");
    if (NUM_CH < 1)                       $error("NUM_CH must be >= 1");
    if (LED_W < 2)                        $error("LED_W must be >= 2");
    if ((2.0 ** IDX_W) < NUM_CH)          $error("IDX_W too small for NUM_CH");

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_active_valid;
    logic [IDX_W-1:0] r_active_idx;
    mode_e            r_mode_q;
    dir_e             r_dir;
    // Only the active channel can ever differ from IDLE, so one pattern
    // register stands in for all channels; the others are IDLE by construction.
    logic [LED_W-1:0] r_pat;

    logic             w_sel_valid;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_reload;
    logic             w_step;

    // Priority encoder: scan downwards so the lowest set bit is the last write.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_sel_idx = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ch_sel[c]) begin
                w_sel_idx = IDX_W'(c);
            end
        end
    end

    assign w_sel_valid = |ch_sel;

    // Any change in selection or mode restarts the animation from IDLE.
    assign w_reload = (w_sel_valid != r_active_valid) ||
                      (w_sel_idx   != r_active_idx)   ||
                      (mode        != r_mode_q);

    // Reload wins over a step landing on the same edge.
    assign w_step = (r_cnt == CNT_LAST) && r_active_valid && !w_reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_tick         <= 1'b0;
            r_active_valid <= 1'b0;
            r_active_idx   <= '0;
            r_mode_q       <= MODE_ROTL;
            r_dir          <= DIR_LEFT;
            r_pat          <= IDLE;
        end else begin
            // NOTE: non-blocking assignments so every right-hand side below
            // reads the pre-edge value, regardless of statement order.
            r_tick <= w_step;

            if (w_reload || r_cnt == CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_reload) begin
                r_active_valid <= w_sel_valid;
                r_active_idx   <= w_sel_idx;
                r_mode_q       <= mode_e'(mode);
                r_dir          <= DIR_LEFT;
                r_pat          <= IDLE;
            end else if (w_step) begin
                unique case (r_mode_q)
                    MODE_ROTL:  r_pat <= {r_pat[LED_W-2:0], r_pat[LED_W-1]};
                    MODE_ROTR:  r_pat <= {r_pat[0], r_pat[LED_W-1:1]};
                    MODE_BLINK: r_pat <= ~r_pat;
                    MODE_BOUNCE: begin
                        // Direction flips on the step that lands on an end bit,
                        // so the lit bit never wraps around.
                        if (r_dir == DIR_LEFT) begin
                            r_pat <= r_pat << 1;
                            if (r_pat[LED_W-2]) r_dir <= DIR_RIGHT;
                        end else begin
                            r_pat <= r_pat >> 1;
                            if (r_pat[1]) r_dir <= DIR_LEFT;
                        end
                    end
                endcase
            end
        end
    end

    // Fan the active pattern out to its channel; all others show IDLE.
    always_comb begin
        leds = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_active_valid && r_active_idx == IDX_W'(c)) begin
                leds[c*LED_W +: LED_W] = r_pat;
            end else begin
                leds[c*LED_W +: LED_W] = IDLE;
            end
        end
    end

    assign active_valid = r_active_valid;
    assign active_idx   = r_active_idx;
    assign tick         = r_tick;

endmodule

// File: tb/tb_led_channel_animator.sv
// ---------------------------------------------------------------------------
// tb_led_channel_animator
//
// Table of per-cycle vectors for rotate-left, hand-written sequences for
// reset, priority/switch, bounce ends, reload-vs-step collision and deselect,
// then randomized ch_sel/mode against a reference model that derives the
// expected pattern from "steps taken since the last reload".
// ---------------------------------------------------------------------------
module tb_led_channel_animator;

    localparam int T      = 4;
    localparam int NCH    = 3;
    localparam int W      = 4;
    localparam int IW     = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NCH-1:0]      ch_sel = '0;
    logic [1:0]          mode = '0;
    logic [NCH*W-1:0]    leds;
    logic                active_valid;
    logic [IW-1:0]       active_idx;
    logic                tick;

    int n_checks = 0;
    int n_fail   = 0;

    led_channel_animator #(
        .TICK_CYCLES(T), .CNT_W(2), .NUM_CH(NCH), .LED_W(W), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst(rst), .ch_sel(ch_sel), .mode(mode),
        .leds(leds), .active_valid(active_valid),
        .active_idx(active_idx), .tick(tick)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic       m_valid = 1'b0;
    logic [1:0] m_idx   = '0;
    logic [1:0] m_mode  = '0;
    int         m_age   = 0;   // edges since the last reload
    int         m_k     = 0;   // steps since the last reload
    logic       m_tick  = 1'b0;

    // Pattern after k steps from IDLE, from the mode's rule in closed form.
    function automatic logic [W-1:0] model_pat(input logic [1:0] md, input int k);
        int p;
        case (md)
            2'd0:    p = k % W;
            2'd1:    p = (W - (k % W)) % W;
            2'd2:    return (k % 2 == 1) ? ~W'(1) : W'(1);
            default: begin
                p = k % (2 * W - 2);
                if (p >= W) p = 2 * W - 2 - p;
            end
        endcase
        return W'(1 << p);
    endfunction

    function automatic logic [NCH*W-1:0] model_leds();
        logic [NCH*W-1:0] v;
        for (int c = 0; c < NCH; c++) begin
            if (m_valid && int'(m_idx) == c) v[c*W +: W] = model_pat(m_mode, m_k);
            else                             v[c*W +: W] = W'(1);
        end
        return v;
    endfunction

    task automatic model_update();
        logic       sv;
        logic [1:0] si;
        if (rst) begin
            m_valid = 1'b0; m_idx = '0; m_mode = '0;
            m_age = 0; m_k = 0; m_tick = 1'b0;
            return;
        end
        sv = |ch_sel;
        si = '0;
        for (int c = NCH - 1; c >= 0; c--) if (ch_sel[c]) si = 2'(c);
        if (sv != m_valid || si != m_idx || mode != m_mode) begin
            m_valid = sv; m_idx = si; m_mode = mode;
            m_age = 0; m_k = 0; m_tick = 1'b0;
        end else begin
            m_age++;
            if (m_valid && (m_age % T == 0)) begin
                m_k++;
                m_tick = 1'b1;
            end else begin
                m_tick = 1'b0;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NCH-1:0]   ch_sel;
        logic [1:0]       mode;
        logic [NCH*W-1:0] leds;
        logic             tick;
        logic             valid;
        logic [IW-1:0]    idx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [NCH*W-1:0] l, input logic t);
        vec_t v;
        v.ch_sel = 3'b010; v.mode = 2'b00;
        v.leds = l; v.tick = t; v.valid = 1'b1; v.idx = 2'd1;
        return v;
    endfunction

    logic [W-1:0] bounce_exp [8];
    int           n_ticks;

    initial begin
        // Rotate-left on channel 1: reload edge, then a step every 4 edges.
        vecs.push_back(mk(12'h111, 1'b0));
        for (int s = 0; s < 4; s++) begin
            logic [NCH*W-1:0] l;
            case (s)
                0: l = 12'h121;
                1: l = 12'h141;
                2: l = 12'h181;
                default: l = 12'h111;
            endcase
            vecs.push_back(mk(vecs[vecs.size()-1].leds, 1'b0));
            vecs.push_back(mk(vecs[vecs.size()-1].leds, 1'b0));
            vecs.push_back(mk(vecs[vecs.size()-1].leds, 1'b0));
            vecs.push_back(mk(l, 1'b1));
        end
        bounce_exp = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};

        // Reset state.
        run(2);
        check("rst_leds",  32'(leds), 32'h111);
        check("rst_tick",  32'(tick), 32'h0);
        check("rst_valid", 32'(active_valid), 32'h0);
        rst = 1'b0;
        cyc();
        check("post_rst_leds", 32'(leds), 32'h111);
        check("post_rst_idx",  32'(active_idx), 32'h0);

        // Table: rotate-left.
        foreach (vecs[i]) begin
            ch_sel = vecs[i].ch_sel;
            mode   = vecs[i].mode;
            cyc();
            check($sformatf("rotl_leds[%0d]", i),  32'(leds), 32'(vecs[i].leds));
            check($sformatf("rotl_tick[%0d]", i),  32'(tick), 32'(vecs[i].tick));
            check($sformatf("rotl_valid[%0d]", i), 32'(active_valid), 32'(vecs[i].valid));
            check($sformatf("rotl_idx[%0d]", i),   32'(active_idx), 32'(vecs[i].idx));
        end

        // Reset mid-animation with channel 1 at 0100.
        run(8);
        check("pre_rst_leds", 32'(leds), 32'h141);
        rst = 1'b1;
        #1;
        check("async_rst_leds",  32'(leds), 32'h111);
        check("async_rst_tick",  32'(tick), 32'h0);
        check("async_rst_valid", 32'(active_valid), 32'h0);
        run(2);
        rst = 1'b0;
        ch_sel = 3'b000;
        cyc();
        check("rel_leds",  32'(leds), 32'h111);
        check("rel_valid", 32'(active_valid), 32'h0);

        // Priority and switch.
        ch_sel = 3'b110;
        cyc();
        check("prio_idx",   32'(active_idx), 32'h1);
        check("prio_valid", 32'(active_valid), 32'h1);
        run(4);
        check("prio_step", 32'(leds), 32'h121);
        run(2);
        ch_sel = 3'b100;
        cyc();
        check("switch_leds", 32'(leds), 32'h111);
        check("switch_idx",  32'(active_idx), 32'h2);
        run(3);
        check("switch_early_leds", 32'(leds), 32'h111);
        check("switch_early_tick", 32'(tick), 32'h0);
        cyc();
        check("switch_step_leds", 32'(leds), 32'h211);
        check("switch_step_tick", 32'(tick), 32'h1);

        // Bounce across both ends.
        ch_sel = 3'b001;
        mode   = 2'b11;
        cyc();
        check("bounce_idx", 32'(active_idx), 32'h0);
        for (int s = 0; s < 8; s++) begin
            run(4);
            check($sformatf("bounce[%0d]", s), 32'(leds), {20'h0, 8'h11, bounce_exp[s]});
            check($sformatf("bounce_tick[%0d]", s), 32'(tick), 32'h1);
        end

        // Blink, then a mode change on the edge a step would land.
        mode = 2'b10;
        cyc();
        check("blink_reload", 32'(leds), 32'h111);
        run(4);
        check("blink_1", 32'(leds), 32'h11E);
        run(4);
        check("blink_2", 32'(leds), 32'h111);
        run(3);
        mode = 2'b01;
        cyc();
        check("collide_leds", 32'(leds), 32'h111);
        check("collide_tick", 32'(tick), 32'h0);
        run(3);
        check("rotr_wait", 32'(leds), 32'h111);
        cyc();
        check("rotr_step", 32'(leds), 32'h118);
        check("rotr_tick", 32'(tick), 32'h1);

        // Deselect mid-rotate.
        run(2);
        ch_sel = 3'b000;
        cyc();
        check("desel_leds",  32'(leds), 32'h111);
        check("desel_valid", 32'(active_valid), 32'h0);
        check("desel_idx",   32'(active_idx), 32'h0);
        n_ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (tick) n_ticks++;
        end
        check("idle_ticks", 32'(n_ticks), 32'h0);

        // Randomized selection/mode changes against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0)  ch_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) mode   = 2'($urandom_range(0, 3));
            cyc();
            check("rand_leds",  32'(leds), 32'(model_leds()));
            check("rand_tick",  32'(tick), 32'(m_tick));
            check("rand_valid", 32'(active_valid), 32'(m_valid));
            check("rand_idx",   32'(active_idx), 32'(m_idx));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_channel_animator.md
Name: led_channel_animator

Overview:
- Parametrised successor to the vending machine's single-speed LED state indicator.
- Drives NUM_CH LED groups of LED_W bits each. A priority-selected channel animates on a programmable tick in one of four modes; all other channels hold the idle pattern.
- Sits between the vending FSM (which supplies the per-state select lines) and the board LED pins.

Parameters:
- TICK_CYCLES, 50_000_000: clk cycles per animation step (1 s at 50 MHz); must be >= 2.
- CNT_W, 26: prescaler width; must satisfy 2^CNT_W >= TICK_CYCLES.
- NUM_CH, 7: number of LED channels; must be >= 1.
- LED_W, 4: LEDs per channel; must be >= 2.
- IDX_W, 3: width of active_idx; must satisfy 2^IDX_W >= NUM_CH.

Ports:
- clk  in  1  system clock, 50 MHz, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ch_sel  in  NUM_CH  channel request lines, one per FSM state; lowest set index wins.
- mode  in  2  animation mode: 00 rotate-left, 01 rotate-right, 10 blink, 11 bounce.
- leds  out  NUM_CH*LED_W  channel c occupies bits [c*LED_W +: LED_W]; high = lit.
- active_valid  out  1  a channel is currently animating.
- active_idx  out  IDX_W  index of the animating channel; 0 when active_valid=0.
- tick  out  1  one-cycle pulse on each animation step.

Behaviour:
- Reset (async, rst=1):
  - every channel pattern = IDLE (bit 0 set, all other bits clear, e.g. 0001);
  - prescaler = 0, tick = 0, active_valid = 0, active_idx = 0;
  - bounce direction = left, mode_q = 00.
  - Outputs stay at these values while rst is high. Release is synchronous to the next clk edge.
- Selection: each cycle, sel_idx = lowest set bit of ch_sel; sel_valid = |ch_sel.
  - Registered into active_valid/active_idx, so outputs follow ch_sel with 1-cycle latency.
- Prescaler: counts 0..TICK_CYCLES-1 and wraps to 0.
  - step = (cnt == TICK_CYCLES-1) and active_valid, with no reload in the same cycle.
  - tick is registered: it is high for the cycle after the step edge.
  - The prescaler free-runs while nothing is selected.
- Reload event: occurs when sel_valid/sel_idx differs from active_valid/active_idx, or mode differs from mode_q. On the same edge:
  - prescaler = 0;
  - all patterns = IDLE;
  - direction = left;
  - mode_q = mode;
  - active regs updated.
  - Reload has priority over step when both fall in the same cycle; no step occurs that cycle.
  - Consequence: the first step after any selection or mode change lands exactly TICK_CYCLES cycles after the reload edge.
- Step, applied to the active channel pattern p only:
  - ROTL: p <= {p[LED_W-2:0], p[LED_W-1]}.
  - ROTR: p <= {p[0], p[LED_W-1:1]}.
  - BLINK: p <= ~p, so IDLE alternates with its complement (0001 -> 1110 -> 0001).
  - BOUNCE: the single lit bit moves one position in the current direction. Direction flips to right on the step that reaches bit LED_W-1, and flips to left on the step that reaches bit 0. It never wraps. LED_W=4 sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
- Non-active channels hold IDLE at all times.
- With no channel selected, all channels show IDLE (matches the machine's idle display).
- mode is sampled only through mode_q. A mid-animation mode change therefore always restarts from IDLE and never applies one mode's rule to another mode's pattern.
- All logic is in a single clock domain. ch_sel and mode are synchronous to clk; the FSM drives them from registers.

Test Plan:
Bench parameters: TICK_CYCLES=4, NUM_CH=3, LED_W=4.
1. Reset mid-animation: assert rst for 2 cycles while channel 1 shows 0100 -> leds=0x111, tick=0, active_valid=0 immediately (async); after release with ch_sel=000, leds stay 0x111.
2. Rotate-left: ch_sel=010, mode=00 -> active_idx=1 one cycle later; channel 1 steps 0010, 0100, 1000, 0001 at 4-cycle spacing, with one tick pulse per step; channels 0 and 2 stay 0001.
3. Priority and switch: ch_sel=110 -> channel 1 animates. Then ch_sel=100 mid-pattern -> next edge channel 1 = 0001, active_idx=2; channel 2's first step (0010) comes 4 cycles after the reload.
4. Bounce boundaries: ch_sel=001, mode=11, 8 steps -> channel 0 sequence 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100.
5. Blink plus mode change colliding with a step: mode=10 gives 1110, 0001. Change mode to 01 on the cycle where cnt=3 -> no step that cycle, pattern=0001, first ROTR step 1000 arrives 4 cycles later.
6. Deselect: ch_sel 001 -> 000 mid-rotate -> next edge leds=0x111, active_valid=0, active_idx=0; no further tick pulses while idle.
